// File: rtl/ex_operand_stage_pkg.sv
// Shared types for the ID/EX operand stage: ALU opcodes, forwarding-source
// selector, the registered instruction payload and the write-back refresh helper.
package ex_operand_stage_pkg;

    localparam int CORE_XLEN       = 32;
    localparam int CORE_REG_ADDR_W = 5;

    // ALU operation; ALU_ADD is the all-zero encoding so a reset payload reads as ADD.
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_t;

    // Where a forwarded source operand came from.
    typedef enum logic [1:0] {
        FWD_NONE  = 2'd0,
        FWD_EXMEM = 2'd1,
        FWD_MEMWB = 2'd2,
        FWD_ZERO  = 2'd3
    } fwd_sel_t;

    // Everything decode hands over for one instruction (handshake excluded).
    typedef struct packed {
        alu_t                         alu_ctrl;
        logic [CORE_REG_ADDR_W-1:0]   rs1_addr;
        logic [CORE_REG_ADDR_W-1:0]   rs2_addr;
        logic [CORE_XLEN-1:0]         rs1_data;
        logic [CORE_XLEN-1:0]         rs2_data;
        logic [CORE_REG_ADDR_W-1:0]   rd_addr;
        logic                         reg_write;
        logic [CORE_XLEN-1:0]         imm;
        logic [CORE_XLEN-1:0]         pc;
        logic [CORE_XLEN-1:0]         pc_plus_4;
        logic                         op1_pc;
        logic                         op2_imm;
        logic                         lui;
        logic                         jump;
    } id_ex_payload_t;

    // Overwrite stored source data with a MEM/WB write that targets it, so an
    // entry that sits in the stage while the producer retires never goes stale.
    function automatic id_ex_payload_t refresh_payload(
        input id_ex_payload_t              p,
        input logic                        wr_en,
        input logic [CORE_REG_ADDR_W-1:0]  rd,
        input logic [CORE_XLEN-1:0]        data
    );
        id_ex_payload_t r;
        r = p;
        if (wr_en && (rd != '0)) begin
            if (p.rs1_addr == rd) r.rs1_data = data;
            if (p.rs2_addr == rd) r.rs2_data = data;
        end
        return r;
    endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Forwarding mux for one source operand: x0 reads as zero, EX/MEM beats
// MEM/WB, otherwise the value read from the register file is used.
module ex_fwd_mux
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN       = CORE_XLEN,
    parameter int REG_ADDR_W = CORE_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       rs_data,
    input  logic                  exmem_wr_en,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_data,
    input  logic                  memwb_wr_en,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_data,
    output logic [XLEN-1:0]       fwd_data,
    output fwd_sel_t              fwd_sel
);

    // Priority select of the forwarding source, youngest producer first.
    always_comb begin
        fwd_sel  = FWD_NONE;
        fwd_data = rs_data;
        if (rs_addr == '0) begin
            fwd_sel  = FWD_ZERO;
            fwd_data = '0;
        end else if (exmem_wr_en && (exmem_rd == rs_addr)) begin
            fwd_sel  = FWD_EXMEM;
            fwd_data = exmem_data;
        end else if (memwb_wr_en && (memwb_rd == rs_addr)) begin
            fwd_sel  = FWD_MEMWB;
            fwd_data = memwb_data;
        end
    end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: two-entry (main + skid) holding register in front of
// the ALU, with operand forwarding and operand-source selection on the output.
module ex_operand_stage
    import ex_operand_stage_pkg::*;
#(
    parameter int XLEN       = CORE_XLEN,
    parameter int REG_ADDR_W = CORE_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  alu_t                  in_alu_ctrl,
    input  logic [REG_ADDR_W-1:0] in_rs1_addr,
    input  logic [REG_ADDR_W-1:0] in_rs2_addr,
    input  logic [XLEN-1:0]       in_rs1_data,
    input  logic [XLEN-1:0]       in_rs2_data,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic                  in_reg_write,
    input  logic [XLEN-1:0]       in_imm,
    input  logic [XLEN-1:0]       in_pc,
    input  logic [XLEN-1:0]       in_pc_plus_4,
    input  logic                  in_op1_pc,
    input  logic                  in_op2_imm,
    input  logic                  in_lui,
    input  logic                  in_jump,
    input  logic                  exmem_wr_en,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_data,
    input  logic                  memwb_wr_en,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output alu_t                  alu_ctrl,
    output logic [XLEN-1:0]       op1,
    output logic [XLEN-1:0]       op2,
    output logic                  lui,
    output logic                  jump,
    output logic [XLEN-1:0]       imm,
    output logic [XLEN-1:0]       pc_plus_4,
    output logic [XLEN-1:0]       rs2_fwd,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic                  reg_write
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; a valid producer holds its payload stable until it transfers.
    // in_ready depends only on registered state (and reset), never on
    // out_ready, so downstream stalls are absorbed by the skid entry.

    id_ex_payload_t main_q, skid_q;
    logic           main_valid, skid_valid;
    id_ex_payload_t in_pl, in_ref, main_ref, skid_ref;
    logic           accept, drain;
    logic [XLEN-1:0] rs1_fwd, rs2_val;
    fwd_sel_t       rs1_sel, rs2_sel;

    assign in_pl = '{
        alu_ctrl:  in_alu_ctrl,
        rs1_addr:  in_rs1_addr,
        rs2_addr:  in_rs2_addr,
        rs1_data:  in_rs1_data,
        rs2_data:  in_rs2_data,
        rd_addr:   in_rd_addr,
        reg_write: in_reg_write,
        imm:       in_imm,
        pc:        in_pc,
        pc_plus_4: in_pc_plus_4,
        op1_pc:    in_op1_pc,
        op2_imm:   in_op2_imm,
        lui:       in_lui,
        jump:      in_jump
    };

    assign in_ready  = !skid_valid && !reset;
    assign out_valid = main_valid;
    assign accept    = in_valid && in_ready;
    assign drain     = main_valid && out_ready;

    // Apply this cycle's MEM/WB write to the incoming and both held entries.
    always_comb begin
        in_ref   = refresh_payload(in_pl,  memwb_wr_en, memwb_rd, memwb_data);
        main_ref = refresh_payload(main_q, memwb_wr_en, memwb_rd, memwb_data);
        skid_ref = refresh_payload(skid_q, memwb_wr_en, memwb_rd, memwb_data);
    end

    // Main/skid occupancy and payload update; flush drops everything held.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            main_q <= main_ref;
            skid_q <= skid_ref;
            if (flush) begin
                main_valid <= 1'b0;
                skid_valid <= 1'b0;
            end else if (!main_valid) begin
                if (accept) begin
                    main_q     <= in_ref;
                    main_valid <= 1'b1;
                end
            end else if (drain) begin
                if (skid_valid) begin
                    main_q     <= skid_ref;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_q <= in_ref;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q     <= in_ref;
                skid_valid <= 1'b1;
            end
        end
    end

    ex_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs1 (
        .rs_addr     (main_q.rs1_addr),
        .rs_data     (main_q.rs1_data),
        .exmem_wr_en (exmem_wr_en),
        .exmem_rd    (exmem_rd),
        .exmem_data  (exmem_data),
        .memwb_wr_en (memwb_wr_en),
        .memwb_rd    (memwb_rd),
        .memwb_data  (memwb_data),
        .fwd_data    (rs1_fwd),
        .fwd_sel     (rs1_sel)
    );

    ex_fwd_mux #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) u_fwd_rs2 (
        .rs_addr     (main_q.rs2_addr),
        .rs_data     (main_q.rs2_data),
        .exmem_wr_en (exmem_wr_en),
        .exmem_rd    (exmem_rd),
        .exmem_data  (exmem_data),
        .memwb_wr_en (memwb_wr_en),
        .memwb_rd    (memwb_rd),
        .memwb_data  (memwb_data),
        .fwd_data    (rs2_val),
        .fwd_sel     (rs2_sel)
    );

    assign alu_ctrl  = main_q.alu_ctrl;
    assign op1       = main_q.op1_pc  ? main_q.pc  : rs1_fwd;
    assign op2       = main_q.op2_imm ? main_q.imm : rs2_val;
    assign rs2_fwd   = rs2_val;
    assign lui       = main_q.lui;
    assign jump      = main_q.jump;
    assign imm       = main_q.imm;
    assign pc_plus_4 = main_q.pc_plus_4;
    assign rd_addr   = main_q.rd_addr;
    assign reg_write = main_q.reg_write && main_valid;

    // A zero-register source must always forward zero regardless of bypass traffic.
    a_rs1_zero: assert property (@(posedge clk) disable iff (reset)
        (rs1_sel == FWD_ZERO) |-> (rs1_fwd == '0));
    a_rs2_zero: assert property (@(posedge clk) disable iff (reset)
        (rs2_sel == FWD_ZERO) |-> (rs2_val == '0));

endmodule

// File: tb/tb_ex_operand_stage.sv
// Bench for ex_operand_stage: directed scenarios plus random traffic, all
// checked every cycle against a 2-deep FIFO reference model.
module tb_ex_operand_stage;
    import ex_operand_stage_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    alu_t        in_alu_ctrl = ALU_ADD;
    logic [4:0]  in_rs1_addr = '0, in_rs2_addr = '0, in_rd_addr = '0;
    logic [31:0] in_rs1_data = '0, in_rs2_data = '0, in_imm = '0, in_pc = '0, in_pc_plus_4 = '0;
    logic        in_reg_write = 1'b0, in_op1_pc = 1'b0, in_op2_imm = 1'b0, in_lui = 1'b0, in_jump = 1'b0;
    logic        exmem_wr_en = 1'b0, memwb_wr_en = 1'b0;
    logic [4:0]  exmem_rd = '0, memwb_rd = '0;
    logic [31:0] exmem_data = '0, memwb_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    alu_t        alu_ctrl;
    logic [31:0] op1, op2, imm, pc_plus_4, rs2_fwd;
    logic        lui, jump, reg_write;
    logic [4:0]  rd_addr;

    always #5 clk = ~clk;

    ex_operand_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_ctrl(in_alu_ctrl), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_rd_addr(in_rd_addr),
        .in_reg_write(in_reg_write), .in_imm(in_imm), .in_pc(in_pc), .in_pc_plus_4(in_pc_plus_4),
        .in_op1_pc(in_op1_pc), .in_op2_imm(in_op2_imm), .in_lui(in_lui), .in_jump(in_jump),
        .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
        .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_ctrl(alu_ctrl), .op1(op1), .op2(op2), .lui(lui), .jump(jump),
        .imm(imm), .pc_plus_4(pc_plus_4), .rs2_fwd(rs2_fwd),
        .rd_addr(rd_addr), .reg_write(reg_write)
    );

    // ---------------- reference model state ----------------
    typedef struct {
        alu_t        alu;
        logic [4:0]  a1, a2, rd;
        logic [31:0] d1, d2, imm, pc, pc4;
        logic        rw, op1_pc, op2_imm, lui, jump;
    } txn_t;

    txn_t        exp_q[$];   // instructions the stage should be holding, oldest first
    logic [31:0] got_log[$]; // imm of every instruction the DUT handed downstream
    txn_t        cur;        // what is presented on the input side right now
    int          vectors = 0;
    int          miscompares = 0;

    // ---------------- scoreboard ----------------
    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Operand value the ALU should see for a source register, from the
    // architectural rule: x0 is zero, the youngest in-flight write wins.
    function automatic logic [31:0] exp_src(input logic [4:0] a, input logic [31:0] held);
        if (a == 5'd0) return 32'd0;
        if (exmem_wr_en && exmem_rd == a) return exmem_data;
        if (memwb_wr_en && memwb_rd == a) return memwb_data;
        return held;
    endfunction

    // ---------------- driver tasks ----------------
    function automatic txn_t rand_txn();
        txn_t t;
        t.alu     = alu_t'(4'($urandom_range(0, 9)));
        t.a1      = 5'($urandom_range(0, 7));
        t.a2      = 5'($urandom_range(0, 7));
        t.rd      = 5'($urandom_range(0, 31));
        t.d1      = $urandom;
        t.d2      = $urandom;
        t.imm     = $urandom;
        t.pc      = $urandom & 32'hFFFF_FFFC;
        t.pc4     = t.pc + 32'd4;
        t.rw      = 1'($urandom_range(0, 1));
        t.op1_pc  = ($urandom_range(0, 3) == 0);
        t.op2_imm = ($urandom_range(0, 2) == 0);
        t.lui     = 1'($urandom_range(0, 1));
        t.jump    = 1'($urandom_range(0, 1));
        return t;
    endfunction

    task automatic present(input txn_t t);
        cur          = t;
        in_valid     = 1'b1;
        in_alu_ctrl  = t.alu;
        in_rs1_addr  = t.a1;
        in_rs2_addr  = t.a2;
        in_rs1_data  = t.d1;
        in_rs2_data  = t.d2;
        in_rd_addr   = t.rd;
        in_reg_write = t.rw;
        in_imm       = t.imm;
        in_pc        = t.pc;
        in_pc_plus_4 = t.pc4;
        in_op1_pc    = t.op1_pc;
        in_op2_imm   = t.op2_imm;
        in_lui       = t.lui;
        in_jump      = t.jump;
    endtask

    task automatic quiet_bus();
        exmem_wr_en = 1'b0;
        memwb_wr_en = 1'b0;
    endtask

    // Called at a negedge with inputs set: check outputs, advance the model,
    // and return at the next negedge.
    task automatic step();
        txn_t h;
        bit   acc, drn;
        #1;
        check_val("in_ready", 32'(in_ready), 32'(!reset && exp_q.size() < 2));
        check_val("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            h = exp_q[0];
            check_val("reg_write", 32'(reg_write), 32'(h.rw));
            check_val("alu_ctrl", 32'(alu_ctrl), 32'(h.alu));
            check_val("op1", op1, h.op1_pc ? h.pc : exp_src(h.a1, h.d1));
            check_val("op2", op2, h.op2_imm ? h.imm : exp_src(h.a2, h.d2));
            check_val("rs2_fwd", rs2_fwd, exp_src(h.a2, h.d2));
            check_val("imm", imm, h.imm);
            check_val("pc_plus_4", pc_plus_4, h.pc4);
            check_val("rd_addr", 32'(rd_addr), 32'(h.rd));
            check_val("lui_jump", 32'({lui, jump}), 32'({h.lui, h.jump}));
        end else begin
            check_val("reg_write_idle", 32'(reg_write), 32'd0);
        end
        if (out_valid && out_ready) got_log.push_back(imm);

        acc = in_valid && !reset && (exp_q.size() < 2);
        drn = (exp_q.size() > 0) && out_ready;
        if (reset || flush) begin
            exp_q.delete();
        end else begin
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(cur);
            if (memwb_wr_en && memwb_rd != 5'd0) begin
                foreach (exp_q[i]) begin
                    if (exp_q[i].a1 == memwb_rd) exp_q[i].d1 = memwb_data;
                    if (exp_q[i].a2 == memwb_rd) exp_q[i].d2 = memwb_data;
                end
            end
        end
        @(negedge clk);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        txn_t t;
        int   leaks;

        // reset
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        step();
        #1;
        check_val("reset_op1", op1, 32'd0);
        check_val("reset_alu", 32'(alu_ctrl), 32'(ALU_ADD));
        reset = 1'b0;
        step();

        // back-to-back flow
        got_log.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            t = rand_txn();
            t.imm = 32'hA1 + 32'(i);
            present(t);
            step();
        end
        in_valid = 1'b0;
        repeat (2) step();
        check_val("b2b_count", 32'(got_log.size()), 32'd3);
        if (got_log.size() == 3) begin
            check_val("b2b_0", got_log[0], 32'hA1);
            check_val("b2b_1", got_log[1], 32'hA2);
            check_val("b2b_2", got_log[2], 32'hA3);
        end

        // skid: A,B,C under backpressure, then release
        got_log.delete();
        out_ready = 1'b0;
        for (int c = 0; c < 8; c++) begin
            if (c < 5) begin
                t = rand_txn();
                t.imm = 32'hB1 + 32'(c > 2 ? 2 : c);
                present(t);
            end else begin
                in_valid = 1'b0;
            end
            out_ready = (c >= 3);
            if (c == 2) begin
                #1;
                check_val("skid_full_ready", 32'(in_ready), 32'd0);
            end
            step();
        end
        check_val("skid_count", 32'(got_log.size()), 32'd3);
        if (got_log.size() == 3) begin
            check_val("skid_0", got_log[0], 32'hB1);
            check_val("skid_1", got_log[1], 32'hB2);
            check_val("skid_2", got_log[2], 32'hB3);
        end

        // forwarding priority
        out_ready = 1'b0;
        t = rand_txn();
        t.a1 = 5'd5; t.d1 = 32'h11; t.op1_pc = 1'b0;
        present(t);
        step();
        in_valid = 1'b0;
        exmem_wr_en = 1'b1; exmem_rd = 5'd5; exmem_data = 32'h22;
        memwb_wr_en = 1'b1; memwb_rd = 5'd5; memwb_data = 32'h33;
        #1 check_val("fwd_exmem_wins", op1, 32'h22);
        step();
        exmem_wr_en = 1'b0;
        #1 check_val("fwd_memwb", op1, 32'h33);
        step();
        memwb_wr_en = 1'b0;
        #1 check_val("fwd_refreshed", op1, 32'h33);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        t = rand_txn();
        t.a1 = 5'd0; t.d1 = 32'h55; t.op1_pc = 1'b0;
        present(t);
        step();
        in_valid = 1'b0;
        exmem_wr_en = 1'b1; exmem_rd = 5'd0; exmem_data = 32'h99;
        memwb_wr_en = 1'b1; memwb_rd = 5'd0; memwb_data = 32'h77;
        #1 check_val("fwd_x0", op1, 32'd0);
        out_ready = 1'b1;
        step();
        quiet_bus();
        step();

        // stall refresh
        out_ready = 1'b0;
        t = rand_txn();
        t.a2 = 5'd7; t.d2 = 32'h1; t.op2_imm = 1'b0;
        present(t);
        step();
        in_valid = 1'b0;
        memwb_wr_en = 1'b1; memwb_rd = 5'd7; memwb_data = 32'hDEAD;
        step();
        memwb_wr_en = 1'b0;
        #1;
        check_val("refresh_op2", op2, 32'hDEAD);
        check_val("refresh_rs2", rs2_fwd, 32'hDEAD);
        out_ready = 1'b1;
        repeat (2) step();

        // flush with both entries full plus a new input, then with main only
        got_log.delete();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            t = rand_txn(); t.imm = 32'hF1 + 32'(i);
            present(t);
            step();
        end
        t = rand_txn(); t.imm = 32'hF3;
        present(t);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check_val("flush_ov", 32'(out_valid), 32'd0);
        check_val("flush_ir", 32'(in_ready), 32'd1);
        t = rand_txn(); t.imm = 32'hF4;
        present(t);
        step();
        t = rand_txn(); t.imm = 32'hF5;
        present(t);
        flush = 1'b1;
        step();
        flush = 1'b0;
        in_valid = 1'b0;
        #1 check_val("flush2_ov", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        repeat (3) step();
        leaks = 0;
        foreach (got_log[i]) if (got_log[i] >= 32'hF1 && got_log[i] <= 32'hF5) leaks++;
        check_val("flush_leak", 32'(leaks), 32'd0);

        // operand select
        t = rand_txn();
        t.op1_pc = 1'b1; t.pc = 32'h100; t.op2_imm = 1'b1; t.imm = 32'h8; t.alu = ALU_ADD;
        present(t);
        step();
        in_valid = 1'b0;
        #1;
        check_val("sel_op1_pc", op1, 32'h100);
        check_val("sel_op2_imm", op2, 32'h8);
        step();

        // reset mid-skid
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            present(rand_txn());
            step();
        end
        in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_val("rst_mid_ov", 32'(out_valid), 32'd0);
        check_val("rst_mid_ir", 32'(in_ready), 32'd1);
        step();

        // random traffic
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 2) != 0) present(rand_txn());
            else in_valid = 1'b0;
            out_ready   = ($urandom_range(0, 9) < 7);
            flush       = ($urandom_range(0, 39) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            exmem_wr_en = 1'($urandom_range(0, 1));
            exmem_rd    = 5'($urandom_range(0, 7));
            exmem_data  = $urandom;
            memwb_wr_en = 1'($urandom_range(0, 1));
            memwb_rd    = 5'($urandom_range(0, 7));
            memwb_data  = $urandom;
            step();
        end
        reset = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        quiet_bus();
        out_ready = 1'b1;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
